// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbitration of cpu/echo bytes into a FIFO, drained into tx_engine via load pulses.
module uart_tx_sched #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic [7:0]    cpu_data,
    output logic          cpu_ack,
    input  logic          echo_req,
    input  logic [7:0]    echo_data,
    output logic          echo_ack,
    input  logic          flush,
    input  logic          txrdy,
    output logic          load,
    output logic [7:0]    out_data,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GUARD} state_t;

    state_t        r_state;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_last_echo;
    logic          r_load;
    logic [7:0]    r_out_data;

    logic          w_ok;
    logic          w_cpu_el;
    logic          w_echo_el;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_wdata;

    assign w_ok      = !full && !flush && !reset;
    assign w_cpu_el  = cpu_req && w_ok;
    assign w_echo_el = echo_req && w_ok;
    // On a tie, whoever was not granted last wins.
    assign cpu_ack   = w_cpu_el && (!w_echo_el || r_last_echo);
    assign echo_ack  = w_echo_el && (!w_cpu_el || !r_last_echo);
    assign w_push    = cpu_ack || echo_ack;
    assign w_wdata   = cpu_ack ? cpu_data : echo_data;
    assign w_pop     = (r_state == S_LOAD) && !flush;

    assign count     = r_count;
    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign load      = r_load;
    assign out_data  = r_out_data;

    always_ff @(posedge clk)
        if (w_push)
            r_mem[r_wr_ptr] <= w_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_last_echo <= 1'b1;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_wr_ptr    <= r_wr_ptr + AW'(w_push);
            r_rd_ptr    <= r_rd_ptr + AW'(w_pop);
            r_count     <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (w_push)
                r_last_echo <= echo_ack;
        end
    end

    // GUARD swallows one cycle so a late txrdy drop from tx_engine is not mistaken for readiness.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_load     <= 1'b0;
            r_out_data <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE:
                    if (!empty && txrdy && !flush) begin
                        r_state    <= S_LOAD;
                        r_load     <= 1'b1;
                        r_out_data <= r_mem[r_rd_ptr];
                    end
                S_LOAD: begin
                    r_state <= S_GUARD;
                    r_load  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_load  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed checks of arbitration, FIFO order/wrap, flush and txrdy gating.
module tb_uart_tx_sched;
    logic       clk = 1'b0;
    logic       reset, cpu_req, echo_req, flush, txrdy;
    logic [7:0] cpu_data, echo_data;
    logic       cpu_ack, echo_ack, load, empty, full;
    logic [7:0] out_data;
    logic [3:0] count;

    int         n_asrt = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];

    uart_tx_sched #(.DEPTH(8), .AW(3)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
        .echo_req(echo_req), .echo_data(echo_data), .echo_ack(echo_ack),
        .flush(flush), .txrdy(txrdy), .load(load), .out_data(out_data),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cpu(input logic [7:0] d);
        cpu_req  = 1'b1;
        cpu_data = d;
        #1;
        chk("push_ack", {31'b0, cpu_ack}, 1);
        tick();
        cpu_req = 1'b0;
        exp_q.push_back(d);
    endtask

    task automatic drain(input int n);
        txrdy = 1'b1;
        for (int k = 0; k < n; k++) begin
            tick();
            chk("drain_load", {31'b0, load}, 1);
            chk("drain_data", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
            tick();
            chk("drain_guard", {31'b0, load}, 0);
            chk("drain_cnt", {28'b0, count}, n - k - 1);
            tick();
            chk("drain_idle", {31'b0, load}, 0);
        end
        txrdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nloads;
        int ci;
        int ei;
        reset = 1'b1; cpu_req = 1'b1; cpu_data = 8'h41; echo_req = 1'b0;
        echo_data = 8'h00; flush = 1'b0; txrdy = 1'b1;
        #1;
        chk("rst_ack", {31'b0, cpu_ack}, 0);
        tick();
        tick();
        chk("rst_ack2", {31'b0, cpu_ack}, 0);
        chk("rst_load", {31'b0, load}, 0);
        chk("rst_data", {24'b0, out_data}, 0);
        chk("rst_count", {28'b0, count}, 0);
        chk("rst_empty", {31'b0, empty}, 1);

        reset = 1'b0;
        #1;
        chk("lat_ack_c0", {31'b0, cpu_ack}, 1);
        tick();
        cpu_req = 1'b0;
        chk("lat_count_c1", {28'b0, count}, 1);
        chk("lat_load_c1", {31'b0, load}, 0);
        tick();
        chk("lat_load_c2", {31'b0, load}, 1);
        chk("lat_data_c2", {24'b0, out_data}, 32'h41);
        tick();
        chk("lat_load_c3", {31'b0, load}, 0);
        chk("lat_count_c3", {28'b0, count}, 0);
        tick();
        txrdy = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;

        cpu_req = 1'b1; echo_req = 1'b1; ci = 0; ei = 0;
        for (int i = 0; i < 8; i++) begin
            cpu_data  = 8'(8'hA0 + ci);
            echo_data = 8'(8'hE0 + ei);
            #1;
            chk("rr_cpu_ack", {31'b0, cpu_ack}, (i % 2 == 0) ? 1 : 0);
            chk("rr_echo_ack", {31'b0, echo_ack}, (i % 2 == 1) ? 1 : 0);
            if (i % 2 == 0) begin exp_q.push_back(cpu_data); ci++; end
            else begin exp_q.push_back(echo_data); ei++; end
            tick();
            chk("rr_count", {28'b0, count}, i + 1);
        end
        chk("rr_full", {31'b0, full}, 1);
        #1;
        chk("rr_full_cpu_ack", {31'b0, cpu_ack}, 0);
        chk("rr_full_echo_ack", {31'b0, echo_ack}, 0);
        cpu_req = 1'b0; echo_req = 1'b0;
        drain(8);
        chk("rr_empty", {31'b0, empty}, 1);

        for (int i = 0; i < 6; i++) push_cpu(8'(8'h10 + i));
        drain(6);
        for (int i = 0; i < 5; i++) push_cpu(8'(8'h20 + i));
        chk("wrap_count", {28'b0, count}, 5);
        drain(5);

        for (int i = 0; i < 8; i++) push_cpu(8'(8'h30 + i));
        chk("fp_full", {31'b0, full}, 1);
        cpu_req = 1'b1; cpu_data = 8'h38; txrdy = 1'b1;
        #1;
        chk("fp_ack_idle", {31'b0, cpu_ack}, 0);
        tick();
        chk("fp_load", {31'b0, load}, 1);
        chk("fp_data", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
        #1;
        chk("fp_ack_load", {31'b0, cpu_ack}, 0);
        tick();
        chk("fp_count7", {28'b0, count}, 7);
        #1;
        chk("fp_ack_guard", {31'b0, cpu_ack}, 1);
        exp_q.push_back(8'h38);
        txrdy = 1'b0;
        tick();
        cpu_req = 1'b0;
        chk("fp_count8", {28'b0, count}, 8);
        drain(8);

        for (int i = 0; i < 4; i++) push_cpu(8'(8'h50 + i));
        txrdy = 1'b1;
        tick();
        chk("fl_load", {31'b0, load}, 1);
        chk("fl_data", {24'b0, out_data}, 32'h50);
        flush = 1'b1; cpu_req = 1'b1; cpu_data = 8'h99;
        #1;
        chk("fl_ack", {31'b0, cpu_ack}, 0);
        tick();
        flush = 1'b0; cpu_req = 1'b0;
        chk("fl_count", {28'b0, count}, 0);
        chk("fl_empty", {31'b0, empty}, 1);
        chk("fl_guard_load", {31'b0, load}, 0);
        nloads = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (load) nloads++;
        end
        chk("fl_no_load", nloads, 0);
        txrdy = 1'b0;
        exp_q.delete();

        for (int i = 0; i < 3; i++) push_cpu(8'(8'h60 + i));
        for (int r = 0; r < 3; r++) begin
            txrdy = 1'b1;
            tick();
            chk("gate_load", {31'b0, load}, 1);
            chk("gate_data", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
            txrdy = 1'b0;
            nloads = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (load) nloads++;
            end
            chk("gate_no_load_low", nloads, 0);
        end
        chk("gate_empty", {31'b0, empty}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit-side scheduler for the UART: accepts bytes from two requesters, the processor write path and the receive-echo path, arbitrates them round-robin into a shared DEPTH-entry FIFO, and sequences `tx_engine` by issuing one-cycle `load` pulses whenever the FIFO holds data and `txrdy` is high. It sits between the port-write decode / rx datapath and `tx_engine`, replacing the direct `load`/`out_port` connection.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, minimum 2.
- `AW`, 3, log2(DEPTH).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- `cpu_req`  in  1  processor byte request; held until `cpu_ack`.
- `cpu_data`  in  8  processor byte; valid while `cpu_req`.
- `cpu_ack`  out  1  combinational grant; byte written at end of this cycle.
- `echo_req`  in  1  echo-path byte request; held until `echo_ack`.
- `echo_data`  in  8  echo byte.
- `echo_ack`  out  1  combinational grant for the echo path.
- `flush`  in  1  synchronous FIFO clear.
- `txrdy`  in  1  from `tx_engine`; high means it can accept a byte.
- `load`  out  1  registered one-cycle pulse to `tx_engine`.
- `out_data`  out  8  registered byte to `tx_engine`; valid while `load`=1, held afterwards.
- `count`  out  AW+1  FIFO occupancy, 0..DEPTH.
- `empty`  out  1  `count`==0.
- `full`  out  1  `count`==DEPTH.

## Operation
- **Arbitration:**
  - A requester is eligible when its `req`=1, `full`=0, `flush`=0 and `reset`=0.
  - At most one grant is issued per cycle.
  - If only one requester is eligible, it is granted.
  - If both are eligible, the one not granted most recently wins. The last-grant pointer resets to "echo", so `cpu` wins the first tie.
  - The pointer updates only on a grant.
- **Push:** on grant, the data is written at `wr_ptr`, `wr_ptr` increments mod DEPTH, and `count` increments. There is no push when full, even if a pop occurs in the same cycle (no full-bypass).
- **Drain FSM states:**
  - IDLE: if `empty`=0, `txrdy`=1 and `flush`=0, go to LOAD. At that edge, register `load`=1 and `out_data`=FIFO[`rd_ptr`].
  - LOAD: `load`=1 for exactly this cycle. At the end of the cycle, pop: `rd_ptr`++ and `count`--. Next state is GUARD.
  - GUARD: `load`=0 and `txrdy` is ignored for one cycle, to cover `tx_engine` dropping `txrdy` one cycle after `load`. Next state is IDLE.
- **Simultaneous push and pop:** `count` is unchanged and both pointers advance.
- **Pointers:** wrap-around is natural mod DEPTH. `count` is a separate counter and is never derived from pointer difference.
- **`flush`:**
  - Next edge: pointers and `count` go to 0.
  - Acks are forced to 0 during the flush cycle.
  - If the FSM is in LOAD, the in-flight byte completes (`tx_engine` already has it). FSM continues LOAD→GUARD→IDLE normally. The LOAD-cycle pop is suppressed.
- **Reset (including mid-operation):**
  - Next edge: state=IDLE, `load`=0, `out_data`=8'h00, `count`=0, `empty`=1, `full`=0, pointers 0, last-grant=echo.
  - Acks are forced to 0 while `reset`=1.

## Timing
- Request-to-load latency with an empty FIFO and `txrdy`=1:
  - Grant in cycle n.
  - `count`=1 in cycle n+1, when IDLE decides.
  - `load`=1 in cycle n+2.
  - GUARD in cycle n+3.
  - IDLE in cycle n+4.
- Minimum spacing between `load` pulses is 3 cycles. In practice spacing is bounded by `txrdy`.
- `cpu_ack`/`echo_ack` are combinational from `req`, `full`, `flush`, `reset` and the pointer. No state feeds them except `full` and the pointer.
- `load` is never high on two consecutive cycles. `out_data` changes only on the edge that enters LOAD.
- Status outputs (`count`, `empty`, `full`) are registered and reflect state after the last edge.

## Test plan
- **Reset/idle:** assert `reset` 2 cycles with `cpu_req`=1 → `cpu_ack`=0, `load`=0, `out_data`=00, `count`=0, `empty`=1. Then release with `txrdy`=1 and cpu byte 8'h41 → ack at cycle 0, `load`=1 with `out_data`=41 at cycle 2, `count` back to 0 at cycle 3.
- **Round-robin tie:** `txrdy`=0, both requesters hold `req` with cpu=8'hA0..A3 and echo=8'hE0..E3 → FIFO order A0,E0,A1,E1,A2,E2,A3,E3. `full`=1 after 8 grants. Further reqs get no ack.
- **Drain order/wrap:** fill 8 bytes, raise `txrdy` → 8 `load` pulses 3 cycles apart, in push order. Refill 5 bytes across the pointer wrap → correct order, `count` 5→0.
- **Full with simultaneous pop:** `full`=1, FSM in LOAD, cpu req pending → no ack in the LOAD cycle. Ack the cycle after `count`=7.
- **`flush` during LOAD:** 4 bytes queued, assert `flush` in the LOAD cycle → `load` pulse completes with head byte, `count`=0 next edge, no further `load` even with `txrdy`=1.
- **`txrdy` gating:** `txrdy` toggles low 20 cycles after each `load` → exactly one `load` per `txrdy` rising period. No `load` while `txrdy`=0.
